// File: rtl/pll_lock_supervisor.sv
// Reset/lock sequencer for the ECP5 PLL: pulses PLL RST, qualifies LOCK, releases the datapath
// reset, and re-sequences on lock loss with bounded retries and a failure latch.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    output logic             pll_rst,
    output logic             core_rst,
    output logic             running,
    output logic             failed,
    output logic [2:0]       state,
    output logic [2:0]       retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_T = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int TW    = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]    RETRY_LIMIT  = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAILED    = 3'd4
    } state_t;

    state_t           cur;
    state_t           nxt;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_nxt;
    logic [2:0]       retry_nxt;
    logic [CNT_W-1:0] loss_nxt;
    logic             fail_attempt;
    logic             sync_1;
    logic             lock_s;

    assign state = cur;

    // Failure events outrank a coincident soft request, which in turn outranks forward progress.
    always_comb begin
        nxt          = cur;
        retry_nxt    = retry_cnt;
        loss_nxt     = loss_cnt;
        fail_attempt = 1'b0;
        case (cur)
            ST_PLL_RST: begin
                if (timer == RST_LAST) nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!lock_s && timer == TIMEOUT_LAST) fail_attempt = 1'b1;
                else if (soft_rst_req)                nxt = ST_PLL_RST;
                else if (lock_s)                      nxt = ST_STABLE;
            end
            ST_STABLE: begin
                if (!lock_s)            fail_attempt = 1'b1;
                else if (soft_rst_req)  nxt = ST_PLL_RST;
                else if (timer == STABLE_LAST) begin
                    nxt       = ST_RUN;
                    retry_nxt = 3'd0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    nxt = ST_PLL_RST;
                    if (loss_cnt != '1) loss_nxt = loss_cnt + 1'b1;
                end else if (soft_rst_req) begin
                    nxt = ST_PLL_RST;
                end
            end
            ST_FAILED: begin
                if (soft_rst_req) begin
                    nxt       = ST_PLL_RST;
                    retry_nxt = 3'd0;
                end
            end
            default: nxt = ST_PLL_RST;
        endcase

        if (fail_attempt) begin
            retry_nxt = retry_cnt + 3'd1;
            nxt       = (retry_nxt == RETRY_LIMIT) ? ST_FAILED : ST_PLL_RST;
        end

        if (nxt != cur || cur == ST_RUN || cur == ST_FAILED) timer_nxt = '0;
        else                                                 timer_nxt = timer + 1'b1;
    end

    // Output flags are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cur       <= ST_PLL_RST;
            timer     <= '0;
            retry_cnt <= 3'd0;
            loss_cnt  <= '0;
            sync_1    <= 1'b0;
            lock_s    <= 1'b0;
            pll_rst   <= 1'b1;
            core_rst  <= 1'b1;
            running   <= 1'b0;
            failed    <= 1'b0;
        end else begin
            cur       <= nxt;
            timer     <= timer_nxt;
            retry_cnt <= retry_nxt;
            loss_cnt  <= loss_nxt;
            sync_1    <= pll_locked;
            lock_s    <= sync_1;
            pll_rst   <= (nxt == ST_PLL_RST) || (nxt == ST_FAILED);
            core_rst  <= (nxt != ST_RUN);
            running   <= (nxt == ST_RUN);
            failed    <= (nxt == ST_FAILED);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios with hand-computed cycle expectations,
// then randomized lock/soft-request traffic compared every cycle against a behavioural model.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int MAX_RETRIES   = 3;
    localparam int CNT_W         = 2;

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAILED = 4;

    logic             clkin        = 1'b0;
    logic             rst          = 1'b1;
    logic             pll_locked   = 1'b0;
    logic             soft_rst_req = 1'b0;
    logic             pll_rst;
    logic             core_rst;
    logic             running;
    logic             failed;
    logic [2:0]       state;
    logic [2:0]       retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    int errors    = 0;
    int checks    = 0;
    int edge_cnt  = 0;
    int m_phase   = 0;
    int m_elapsed = 0;
    int m_retries = 0;
    int m_losses  = 0;
    bit m_hist[$];

    always #5 clkin = ~clkin;

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (CNT_W)
    ) dut (
        .clkin       (clkin),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .soft_rst_req(soft_rst_req),
        .pll_rst     (pll_rst),
        .core_rst    (core_rst),
        .running     (running),
        .failed      (failed),
        .state       (state),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic void model_enter(input int ph);
        m_phase   = ph;
        m_elapsed = 0;
    endfunction

    // Behavioural model: the lock seen by the sequencer is the input sampled two edges earlier.
    always @(posedge clkin or posedge rst) begin
        if (rst) begin
            m_phase   = PH_RST;
            m_elapsed = 0;
            m_retries = 0;
            m_losses  = 0;
            m_hist.delete();
            m_hist.push_back(1'b0);
            m_hist.push_back(1'b0);
            edge_cnt  = 0;
        end else begin
            bit seen;
            bit fail;
            seen = m_hist.pop_front();
            m_hist.push_back(pll_locked);
            fail = 1'b0;
            case (m_phase)
                PH_RST: begin
                    if (m_elapsed + 1 == RST_CYCLES) model_enter(PH_WAIT);
                    else m_elapsed++;
                end
                PH_WAIT: begin
                    if (!seen && m_elapsed + 1 == LOCK_TIMEOUT) fail = 1'b1;
                    else if (soft_rst_req) model_enter(PH_RST);
                    else if (seen) model_enter(PH_STABLE);
                    else m_elapsed++;
                end
                PH_STABLE: begin
                    if (!seen) fail = 1'b1;
                    else if (soft_rst_req) model_enter(PH_RST);
                    else if (m_elapsed + 1 == STABLE_CYCLES) begin
                        m_retries = 0;
                        model_enter(PH_RUN);
                    end else m_elapsed++;
                end
                PH_RUN: begin
                    if (!seen) begin
                        if (m_losses < (1 << CNT_W) - 1) m_losses++;
                        model_enter(PH_RST);
                    end else if (soft_rst_req) model_enter(PH_RST);
                end
                default: begin
                    if (soft_rst_req) begin
                        m_retries = 0;
                        model_enter(PH_RST);
                    end
                end
            endcase
            if (fail) begin
                m_retries++;
                model_enter((m_retries == MAX_RETRIES) ? PH_FAILED : PH_RST);
            end
            edge_cnt++;
        end
    end

    // Every cycle out of reset, all outputs must match the model.
    always @(negedge clkin) begin
        if (!rst) begin
            check_output("state",     state,     m_phase);
            check_output("retry_cnt", retry_cnt, m_retries);
            check_output("loss_cnt",  loss_cnt,  m_losses);
            check_output("pll_rst",   pll_rst,   (m_phase == PH_RST || m_phase == PH_FAILED));
            check_output("core_rst",  core_rst,  (m_phase != PH_RUN));
            check_output("running",   running,   (m_phase == PH_RUN));
            check_output("failed",    failed,    (m_phase == PH_FAILED));
        end
    end

    task automatic apply_reset(input bit lock);
        @(negedge clkin);
        rst          = 1'b1;
        soft_rst_req = 1'b0;
        pll_locked   = lock;
        repeat (2) @(negedge clkin);
        rst = 1'b0;
    endtask

    task automatic at_cycle(input int k);
        while (edge_cnt < k) @(negedge clkin);
    endtask

    task automatic wait_state(input int want, input int budget);
        int n;
        n = 0;
        while (state != 3'(want) && n < budget) begin
            @(negedge clkin);
            n++;
        end
        check_output("wait_state", state, want);
    endtask

    task automatic apply_stimulus(input int n_cycles);
        int seg;
        int mode;
        seg  = 0;
        mode = 0;
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clkin);
            if (seg == 0) begin
                seg  = $urandom_range(5, 60);
                mode = $urandom_range(0, 4);
            end
            seg--;
            case (mode)
                0:       pll_locked = 1'b0;
                4:       pll_locked = 1'($urandom_range(0, 1));
                default: pll_locked = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            endcase
            soft_rst_req = ($urandom_range(0, 99) < 2);
        end
        @(negedge clkin);
        soft_rst_req = 1'b0;
    endtask

    initial begin
        // Lock from cycle 10: PLL reset 0-3, STABLE 13-20, RUN from 21; then one lock loss.
        apply_reset(1'b0);
        check_output("t1 pll_rst c0", pll_rst, 1);
        check_output("t1 state c0", state, 0);
        at_cycle(3);  check_output("t1 pll_rst c3", pll_rst, 1);
        at_cycle(4);  check_output("t1 pll_rst c4", pll_rst, 0);
        check_output("t1 state c4", state, 1);
        at_cycle(10); pll_locked = 1'b1;
        at_cycle(12); check_output("t1 state c12", state, 1);
        at_cycle(13); check_output("t1 state c13", state, 2);
        at_cycle(20); check_output("t1 core_rst c20", core_rst, 1);
        at_cycle(21); check_output("t1 core_rst c21", core_rst, 0);
        check_output("t1 running c21", running, 1);
        at_cycle(30); pll_locked = 1'b0;
        at_cycle(31); pll_locked = 1'b1;
        at_cycle(32); check_output("t4 core_rst c32", core_rst, 0);
        at_cycle(33); check_output("t4 core_rst c33", core_rst, 1);
        check_output("t4 loss_cnt c33", loss_cnt, 1);
        at_cycle(45); check_output("t4 running c45", running, 0);
        at_cycle(46); check_output("t4 running c46", running, 1);
        check_output("t4 loss_cnt c46", loss_cnt, 1);

        // No lock: three 36-cycle attempts, FAILED at 108, then soft request and lock.
        apply_reset(1'b0);
        at_cycle(36);  check_output("t2 retry c36", retry_cnt, 1);
        at_cycle(107); check_output("t2 failed c107", failed, 0);
        at_cycle(108); check_output("t2 failed c108", failed, 1);
        check_output("t2 retry c108", retry_cnt, 3);
        check_output("t2 pll_rst c108", pll_rst, 1);
        at_cycle(110); soft_rst_req = 1'b1; pll_locked = 1'b1;
        at_cycle(111); soft_rst_req = 1'b0;
        check_output("t2 failed c111", failed, 0);
        check_output("t2 retry c111", retry_cnt, 0);
        at_cycle(123); check_output("t2 running c123", running, 0);
        at_cycle(124); check_output("t2 running c124", running, 1);

        // One-cycle lock glitch mid-STABLE.
        apply_reset(1'b1);
        at_cycle(8);  pll_locked = 1'b0;
        at_cycle(9);  pll_locked = 1'b1;
        at_cycle(10); check_output("t3 state c10", state, 2);
        at_cycle(11); check_output("t3 state c11", state, 0);
        check_output("t3 retry c11", retry_cnt, 1);
        at_cycle(23); check_output("t3 state c23", state, 2);
        at_cycle(24); check_output("t3 state c24", state, 3);
        check_output("t3 retry c24", retry_cnt, 0);

        // Loss coinciding with soft request counts once; further losses saturate at 3.
        apply_reset(1'b1);
        wait_state(PH_RUN, 200);
        pll_locked = 1'b0;
        @(negedge clkin); pll_locked = 1'b1;
        @(negedge clkin); soft_rst_req = 1'b1;
        @(negedge clkin); soft_rst_req = 1'b0;
        check_output("t5 loss both", loss_cnt, 1);
        for (int i = 2; i <= 5; i++) begin
            wait_state(PH_RUN, 200);
            pll_locked = 1'b0;
            @(negedge clkin); pll_locked = 1'b1;
            repeat (2) @(negedge clkin);
            check_output("t5 loss sat", loss_cnt, (i > 3) ? 3 : i);
            check_output("t5 core_rst", core_rst, 1);
        end

        // Asynchronous reset between edges while in STABLE.
        wait_state(PH_STABLE, 200);
        repeat (2) @(negedge clkin);
        #2 rst = 1'b1;
        #1;
        check_output("t6 state", state, 0);
        check_output("t6 pll_rst", pll_rst, 1);
        check_output("t6 core_rst", core_rst, 1);
        check_output("t6 running", running, 0);
        check_output("t6 failed", failed, 0);
        check_output("t6 loss_cnt", loss_cnt, 0);

        apply_reset(1'b0);
        apply_stimulus(4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
